// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled start/data/stop framing with 3-sample majority vote.
// Delivers each byte with a one-cycle valid or frame-error strobe.
module uart_rx_core #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_en,
  input  logic        nstop,
  input  logic [15:0] baud_div,
  input  logic        rxd,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic        frame_error,
  output logic        rx_busy
);

  // state   | meaning
  // S_IDLE  | line idle, waiting for a low sample on a tick
  // S_START | inside start bit, glitch check at mid-bit
  // S_DATA  | shifting in 8 data bits, LSB first
  // S_STOP1 | first stop bit; finishes here for one stop bit
  // S_STOP2 | second stop bit, always finishes at mid-bit
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP1,
    S_STOP2
  } state_t;

  localparam logic [3:0] SCNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SAMP_A    = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SAMP_B    = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] SAMP_C    = 4'(OVERSAMPLE / 2 + 1);

  state_t      state, state_n;
  logic        rxd_m, rxd_s;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [3:0]  scnt, scnt_n;
  logic [2:0]  bcnt, bcnt_n;
  logic [7:0]  shreg, shreg_n;
  logic        samp_a, samp_a_n;
  logic        samp_b, samp_b_n;
  logic        err, err_n;
  logic        maj;
  logic        finish;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // >= rather than == so lowering baud_div mid-count cannot strand the counter above it
  assign tick = rx_en && (tick_cnt >= baud_div);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= 16'd0;
    end else if (!rx_en || tick) begin
      tick_cnt <= 16'd0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  // third sample is the live one on the scnt = SAMP_C tick
  assign maj = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    scnt_n   = scnt;
    bcnt_n   = bcnt;
    shreg_n  = shreg;
    samp_a_n = samp_a;
    samp_b_n = samp_b;
    err_n    = err;
    finish   = 1'b0;
    if (!rx_en) begin
      state_n = S_IDLE;
      scnt_n  = 4'd0;
    end else if (tick) begin
      scnt_n = scnt + 4'd1;
      if (scnt == SAMP_A) samp_a_n = rxd_s;
      if (scnt == SAMP_B) samp_b_n = rxd_s;
      unique case (state)
        S_IDLE: begin
          scnt_n = 4'd0;
          if (!rxd_s) begin
            state_n = S_START;
            err_n   = 1'b0;
          end
        end
        S_START: begin
          if (scnt == SAMP_C && maj) begin
            state_n = S_IDLE;
            scnt_n  = 4'd0;
          end else if (scnt == SCNT_LAST) begin
            state_n = S_DATA;
            bcnt_n  = 3'd0;
          end
        end
        S_DATA: begin
          if (scnt == SAMP_C) shreg_n = {maj, shreg[7:1]};
          if (scnt == SCNT_LAST) begin
            if (bcnt == 3'd7) state_n = S_STOP1;
            else bcnt_n = bcnt + 3'd1;
          end
        end
        S_STOP1: begin
          if (scnt == SAMP_C) begin
            err_n = err | ~maj;
            if (!nstop) finish = 1'b1;
          end else if (scnt == SCNT_LAST) begin
            state_n = S_STOP2;
          end
        end
        S_STOP2: begin
          if (scnt == SAMP_C) begin
            err_n  = err | ~maj;
            finish = 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          scnt_n  = 4'd0;
        end
      endcase
      // leaving at mid stop bit lets an early next start edge be caught
      if (finish) begin
        state_n = S_IDLE;
        scnt_n  = 4'd0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scnt          <= 4'd0;
      bcnt          <= 3'd0;
      shreg         <= 8'h00;
      samp_a        <= 1'b1;
      samp_b        <= 1'b1;
      err           <= 1'b0;
      rx_data       <= 8'h00;
      rx_data_valid <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      scnt          <= scnt_n;
      bcnt          <= bcnt_n;
      shreg         <= shreg_n;
      samp_a        <= samp_a_n;
      samp_b        <= samp_b_n;
      err           <= err_n;
      rx_data_valid <= finish & ~err_n;
      frame_error   <= finish & err_n;
      if (finish) rx_data <= shreg_n;
    end
  end

  assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: vector table of whole frames plus hand-built
// sequences for glitch, disable, reset and divisor corner cases.
module tb_uart_rx_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_en;
  logic        nstop;
  logic [15:0] baud_div;
  logic        rxd;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        frame_error;
  logic        rx_busy;

  uart_rx_core #(.OVERSAMPLE(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_en         (rx_en),
    .nstop         (nstop),
    .baud_div      (baud_div),
    .rxd           (rxd),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .frame_error   (frame_error),
    .rx_busy       (rx_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        nstop;
    logic [15:0] div;
    logic [7:0]  data;
    logic        stop1;
    logic        stop2;
    logic        exp_valid;
    logic        exp_ferr;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // strobe monitor
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         mon_err = 0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_strobe = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clock) begin
    if (rx_data_valid) begin
      n_valid <= n_valid + 1;
      got_q.push_back(rx_data);
    end
    if (frame_error) n_ferr <= n_ferr + 1;
    if (!reset) begin
      if ((rx_data_valid && frame_error) ||
          ((rx_data_valid || frame_error) && (prev_strobe || rx_busy || !prev_busy)) ||
          (!(rx_data_valid || frame_error) && rx_data != prev_data))
        mon_err <= mon_err + 1;
    end
    prev_data   <= rx_data;
    prev_strobe <= rx_data_valid | frame_error;
    prev_busy   <= rx_busy;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int clks);
    rxd = b;
    repeat (clks) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic two_stop,
                            input logic s1, input logic s2, input int bc);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
    drive_bit(s1, bc);
    if (two_stop) drive_bit(s2, bc);
    rxd = 1'b1;
  endtask

  vec_t vecs[8];

  initial begin
    int         v0, f0, q0, bc;
    logic [7:0] d0;
    logic       seen;

    vecs[0] = '{1'b0, 16'd1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 16'd1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 16'd1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'd1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'd1, 8'h96, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 16'd0, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'd2, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'd1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; rx_en = 1'b0; nstop = 1'b0; baud_div = 16'd1; rxd = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_valid", rx_data_valid, 1'b0);
    check("reset_ferr", frame_error, 1'b0);
    check("reset_busy", rx_busy, 1'b0);
    reset = 1'b0;
    rx_en = 1'b1;
    repeat (8) @(negedge clock);

    foreach (vecs[k]) begin
      nstop    = vecs[k].nstop;
      baud_div = vecs[k].div;
      bc       = 16 * (int'(vecs[k].div) + 1);
      v0 = n_valid; f0 = n_ferr;
      send_frame(vecs[k].data, vecs[k].nstop, vecs[k].stop1, vecs[k].stop2, bc);
      drive_bit(1'b1, 4 * bc);
      check($sformatf("vec%0d_valid", k), n_valid - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d_ferr", k), n_ferr - f0, vecs[k].exp_ferr);
      check($sformatf("vec%0d_data", k), rx_data, vecs[k].data);
      check($sformatf("vec%0d_idle", k), rx_busy, 1'b0);
    end

    // 8N2 back-to-back, no idle gap
    nstop = 1'b1; baud_div = 16'd1;
    v0 = n_valid; q0 = got_q.size();
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, 32);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 32);
    drive_bit(1'b1, 128);
    check("b2b_count", n_valid - v0, 2);
    check("b2b_first", (got_q.size() > q0) ? got_q[q0] : 8'h55, 8'h00);
    check("b2b_second", (got_q.size() > q0 + 1) ? got_q[q0 + 1] : 8'h55, 8'hFF);

    // glitch: low for 3 ticks
    nstop = 1'b0;
    v0 = n_valid; f0 = n_ferr; d0 = rx_data; seen = 1'b0;
    rxd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      seen |= rx_busy;
    end
    rxd = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      seen |= rx_busy;
    end
    check("glitch_busy_seen", seen, 1'b1);
    check("glitch_idle", rx_busy, 1'b0);
    check("glitch_strobes", (n_valid - v0) + (n_ferr - f0), 0);
    check("glitch_data", rx_data, d0);

    // disable after data bit 3
    v0 = n_valid; f0 = n_ferr; d0 = rx_data;
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 32); drive_bit(1'b0, 32); drive_bit(1'b1, 32); drive_bit(1'b0, 32);
    check("dis_busy_before", rx_busy, 1'b1);
    rx_en = 1'b0;
    @(negedge clock);
    check("dis_idle", rx_busy, 1'b0);
    drive_bit(1'b1, 200);
    check("dis_strobes", (n_valid - v0) + (n_ferr - f0), 0);
    check("dis_data_hold", rx_data, d0);
    rx_en = 1'b1;
    drive_bit(1'b1, 32);

    // asynchronous reset mid-frame, then a clean 0x5A
    v0 = n_valid; f0 = n_ferr;
    drive_bit(1'b0, 32); drive_bit(1'b0, 32); drive_bit(1'b1, 32);
    check("rst_busy_before", rx_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_data", rx_data, 8'h00);
    check("rst_async_busy", rx_busy, 1'b0);
    check("rst_async_strobes", {rx_data_valid, frame_error}, 2'b00);
    rxd = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    drive_bit(1'b1, 64);
    check("rst_no_strobe", (n_valid - v0) + (n_ferr - f0), 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 32);
    drive_bit(1'b1, 128);
    check("rst_5a_valid", n_valid - v0, 1);
    check("rst_5a_data", rx_data, 8'h5A);

    // baud_div = 0xFFFF start detect, then divisor lowered mid-frame
    rx_en = 1'b0; baud_div = 16'hFFFF;
    @(negedge clock);
    v0 = n_valid; f0 = n_ferr;
    rxd = 1'b0; rx_en = 1'b1;
    repeat (60000) @(negedge clock);
    check("slow_not_yet", rx_busy, 1'b0);
    for (int i = 0; i < 8000 && !rx_busy; i++) @(negedge clock);
    check("slow_start_seen", rx_busy, 1'b1);
    baud_div = 16'd1;
    drive_bit(1'b0, 32);
    for (int i = 0; i < 8; i++) drive_bit(i == 0 || i == 7, 32);
    drive_bit(1'b1, 32);
    drive_bit(1'b1, 128);
    check("slow_valid", n_valid - v0, 1);
    check("slow_ferr", n_ferr - f0, 0);
    check("slow_data", rx_data, 8'h81);

    check("strobe_protocol", mon_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
